// File: rtl/if_fetch.sv
// RV32I instruction fetch: reads an instruction as four bytes over a shared byte-wide port,
// assembles it little-endian and holds it for IF/ID until downstream consumes it.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        br_taken,
   input  logic [31:0] br_addr,
   input  logic        hold,
   input  logic        mem_busy,
   input  logic [7:0]  mem_din,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stall_req
);

   typedef enum logic {FETCH = 1'b0, DONE = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [2:0]       ic_q, ic_d;
   logic [2:0]       rc_q, rc_d;
   logic             pend_q, pend_d;
   logic [2:0][7:0]  byte_q, byte_d;
   logic [31:0]      if_pc_q, if_pc_d;
   logic [31:0]      if_inst_q, if_inst_d;
   logic             grant;

   // A redirect suppresses issue in its own cycle so no stale-address byte is requested.
   assign mem_req   = rdy & (state_q == FETCH) & (ic_q < 3'd4) & ~br_taken;
   assign mem_addr  = (state_q == FETCH) ? fetch_pc_q + {29'd0, ic_q} : 32'd0;
   assign grant     = mem_req & ~mem_busy;
   assign if_pc     = if_pc_q;
   assign if_inst   = if_inst_q;
   assign stall_req = (state_q == FETCH);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      ic_d       = ic_q;
      rc_d       = rc_q;
      pend_d     = pend_q;
      byte_d     = byte_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if (rdy) begin
         if (br_taken) begin
            // Redirect wins over hold and over a byte arriving this cycle.
            fetch_pc_d = br_addr;
            ic_d       = 3'd0;
            rc_d       = 3'd0;
            pend_d     = 1'b0;
            state_d    = FETCH;
         end else begin
            pend_d = grant;
            if (grant) ic_d = ic_q + 3'd1;
            if (pend_q) begin
               if (rc_q == 3'd3) begin
                  if_inst_d = {mem_din, byte_q[2], byte_q[1], byte_q[0]};
                  if_pc_d   = fetch_pc_q;
                  rc_d      = 3'd4;
                  state_d   = DONE;
               end else begin
                  byte_d[rc_q[1:0]] = mem_din;
                  rc_d              = rc_q + 3'd1;
               end
            end
            if (state_q == DONE && !hold) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               ic_d       = 3'd0;
               rc_d       = 3'd0;
               state_d    = FETCH;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         ic_q       <= 3'd0;
         rc_q       <= 3'd0;
         pend_q     <= 1'b0;
         byte_q     <= '0;
         if_pc_q    <= 32'd0;
         if_inst_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         ic_q       <= ic_d;
         rc_q       <= rc_d;
         pend_q     <= pend_d;
         byte_q     <= byte_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed timing scenarios, then randomized traffic checked against
// an instruction-stream model (expected pc sequence and memory words).
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst, rdy, br_taken, hold, mem_busy;
   logic [31:0] br_addr;
   logic [7:0]  mem_din = 8'd0;
   logic        mem_req, stall_req;
   logic [31:0] mem_addr, if_pc, if_inst;

   logic [7:0]  mem [256];
   int          n_tests = 0;
   int          n_fail  = 0;

   localparam logic [31:0] INST0 = 32'h0010_0513;

   if_fetch #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .br_taken(br_taken), .br_addr(br_addr),
      .hold(hold), .mem_busy(mem_busy), .mem_din(mem_din), .mem_req(mem_req),
      .mem_addr(mem_addr), .if_pc(if_pc), .if_inst(if_inst), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   // byte memory: data appears one cycle after a granted request
   always @(posedge clk) if (mem_req && !mem_busy) mem_din <= mem[mem_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] pc);
      logic [7:0] a;
      a = pc[7:0];
      word = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
   endfunction

   task automatic do_reset();
      rst = 1'b0; rdy = 1'b1; br_taken = 1'b0; br_addr = 32'd0; hold = 1'b0; mem_busy = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic next_cyc();
      @(posedge clk); #1;
   endtask

   logic [31:0] exp_pc;
   int          issued, ndone;
   logic        prev_stall;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

      // reset state
      rst = 1'b0; rdy = 1'b1; br_taken = 1'b0; br_addr = 32'd0; hold = 1'b0; mem_busy = 1'b0;
      #3;
      chk("rst_stall", 32'(stall_req), 32'd1);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_inst", if_inst, 32'd0);
      chk("rst_req", 32'(mem_req), 32'd1);
      chk("rst_addr", mem_addr, 32'd0);

      // 1: uncontended fetch
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c < 4 || c == 6) begin
            chk("t1_req", 32'(mem_req), 32'd1);
            chk("t1_addr", mem_addr, (c == 6) ? 32'd4 : 32'(c));
         end
         if (c == 4) chk("t1_stall4", 32'(stall_req), 32'd1);
         if (c == 5) begin
            chk("t1_stall5", 32'(stall_req), 32'd0);
            chk("t1_inst", if_inst, INST0);
            chk("t1_pc", if_pc, 32'd0);
            chk("t1_req5", 32'(mem_req), 32'd0);
         end
         next_cyc();
      end

      // 2: contention on cycles 1-2
      do_reset();
      for (int c = 0; c < 8; c++) begin
         mem_busy = (c == 1 || c == 2);
         @(negedge clk);
         if (c >= 1 && c <= 3) chk("t2_addr_hold", mem_addr, 32'd1);
         if (c == 5) chk("t2_addr5", mem_addr, 32'd3);
         if (c == 6) chk("t2_stall6", 32'(stall_req), 32'd1);
         if (c == 7) begin
            chk("t2_stall7", 32'(stall_req), 32'd0);
            chk("t2_inst", if_inst, INST0);
         end
         next_cyc();
      end
      mem_busy = 1'b0;

      // 3: redirect during fetch discards the in-flight byte
      do_reset();
      for (int c = 0; c < 9; c++) begin
         br_taken = (c == 2);
         br_addr  = (c == 2) ? 32'h100 : 32'd0;
         @(negedge clk);
         if (c == 2) chk("t3_req_br", 32'(mem_req), 32'd0);
         if (c == 3) chk("t3_addr", mem_addr, 32'h100);
         if (c == 6) chk("t3_addr6", mem_addr, 32'h103);
         if (c == 7) chk("t3_stall7", 32'(stall_req), 32'd1);
         if (c == 8) begin
            chk("t3_stall8", 32'(stall_req), 32'd0);
            chk("t3_pc", if_pc, 32'h100);
            chk("t3_inst", if_inst, word(32'h100));
         end
         next_cyc();
      end
      br_taken = 1'b0;

      // 4: hold in DONE
      do_reset();
      for (int c = 0; c < 10; c++) begin
         hold = (c >= 5 && c <= 7);
         @(negedge clk);
         if (c >= 5 && c <= 8) begin
            chk("t4_stall", 32'(stall_req), 32'd0);
            chk("t4_req", 32'(mem_req), 32'd0);
            chk("t4_pc", if_pc, 32'd0);
            chk("t4_inst", if_inst, INST0);
         end
         if (c == 9) begin
            chk("t4_req9", 32'(mem_req), 32'd1);
            chk("t4_addr9", mem_addr, 32'd4);
         end
         next_cyc();
      end
      hold = 1'b0;

      // 5: asynchronous reset during the second fetch
      do_reset();
      for (int c = 0; c < 8; c++) next_cyc();
      chk("t5_pre_inst", if_inst, INST0);
      #3 rst = 1'b0;
      #1;
      chk("t5_inst", if_inst, 32'd0);
      chk("t5_pc", if_pc, 32'd0);
      chk("t5_stall", 32'(stall_req), 32'd1);
      chk("t5_addr", mem_addr, 32'd0);
      next_cyc();
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) chk("t5_restart", mem_addr, 32'd0);
         if (c == 5) begin
            chk("t5_stall5", 32'(stall_req), 32'd0);
            chk("t5_inst5", if_inst, INST0);
         end
         next_cyc();
      end

      // 6: rdy low on cycles 2-3
      do_reset();
      for (int c = 0; c < 8; c++) begin
         rdy = !(c == 2 || c == 3);
         @(negedge clk);
         if (c == 2 || c == 3) chk("t6_req", 32'(mem_req), 32'd0);
         if (c == 4) chk("t6_addr4", mem_addr, 32'd2);
         if (c == 6) chk("t6_stall6", 32'(stall_req), 32'd1);
         if (c == 7) begin
            chk("t6_stall7", 32'(stall_req), 32'd0);
            chk("t6_inst", if_inst, INST0);
         end
         next_cyc();
      end

      // random traffic against an instruction-stream model
      do_reset();
      exp_pc = 32'd0; issued = 0; ndone = 0; prev_stall = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         rdy      = ($urandom % 8) != 0;
         mem_busy = ($urandom % 4) == 0;
         hold     = ($urandom % 5) == 0;
         br_taken = ($urandom % 40) == 0;
         br_addr  = $urandom;
         @(negedge clk);
         if (!stall_req) begin
            chk("rnd_pc", if_pc, exp_pc);
            chk("rnd_inst", if_inst, word(exp_pc));
            if (prev_stall) ndone++;
         end
         chk("rnd_req", 32'(mem_req), 32'(rdy && !br_taken && stall_req && issued < 4));
         if (mem_req && !mem_busy) begin
            chk("rnd_addr", mem_addr, exp_pc + 32'(issued));
            issued++;
         end
         if (rdy) begin
            if (br_taken) begin
               exp_pc = br_addr; issued = 0;
            end else if (!stall_req && !hold) begin
               exp_pc = exp_pc + 32'd4; issued = 0;
            end
         end
         prev_stall = stall_req;
         next_cyc();
      end
      chk("rnd_progress", 32'(ndone > 50), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
